// File: rtl/wait_count_gen.sv
// Prescaled wait counter that splits its range into PHASES equal segments,
// toggling `out` per segment; one-shot (saturate) or periodic (wrap) operation.
module wait_count_gen #(
    parameter int WIDTH  = 16,
    parameter int PHASES = 4,
    parameter int PRESC  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       rearm,
    input  logic                       periodic,
    output logic                       out,
    output logic                       done,
    output logic [$clog2(PHASES)-1:0]  phase,
    output logic [WIDTH-1:0]           count
);

    localparam int PB    = $clog2(PHASES);
    localparam int LOW_W = WIDTH - PB;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SAT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q,   pre_d;
    logic             out_q,   out_d;
    logic             done_q,  done_d;

    logic step;
    logic at_max;
    logic at_boundary;

    assign step        = (pre_q == PRE_LAST);
    assign at_max      = &count_q;
    // Every segment ends on a value whose low (in-segment) bits are all ones.
    assign at_boundary = &count_q[LOW_W-1:0];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        out_d   = out_q;
        done_d  = 1'b0;

        if (rearm) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
            out_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (start) begin
                        state_d = IDLE;
                        count_d = '0;
                        pre_d   = '0;
                        out_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                        if (step) begin
                            pre_d = '0;
                            if (at_max) begin
                                out_d  = 1'b0;
                                done_d = 1'b1;
                                if (periodic) begin
                                    count_d = '0;
                                end else begin
                                    state_d = SAT;
                                end
                            end else begin
                                count_d = count_q + 1'b1;
                                // Leaving the end of an even segment enters an odd one.
                                if (at_boundary) begin
                                    out_d = ~count_q[LOW_W];
                                end
                            end
                        end else begin
                            pre_d = pre_q + 1'b1;
                        end
                    end
                end
                SAT: begin
                    out_d  = 1'b0;
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    pre_d   = '0;
                    out_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign done  = done_q;
    assign count = count_q;
    assign phase = count_q[WIDTH-1 -: PB];

endmodule

// File: tb/tb_wait_count_gen.sv
// Bench for wait_count_gen: two configurations share one stimulus stream and
// are checked against a segment/step-level reference model plus directed vectors.
module tb_wait_count_gen;

    logic clk = 1'b0;
    logic rst_n, start, rearm, periodic;

    logic       out_a, done_a;
    logic [1:0] phase_a;
    logic [3:0] count_a;
    logic       out_b, done_b;
    logic [0:0] phase_b;
    logic [3:0] count_b;

    always #5 clk = ~clk;

    wait_count_gen #(.WIDTH(4), .PHASES(4), .PRESC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .rearm(rearm), .periodic(periodic),
        .out(out_a), .done(done_a), .phase(phase_a), .count(count_a)
    );

    wait_count_gen #(.WIDTH(4), .PHASES(2), .PRESC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .rearm(rearm), .periodic(periodic),
        .out(out_b), .done(done_b), .phase(phase_b), .count(count_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: step counter, prescale position, sticky/pulse done.
    int presc_v[2] = '{1, 3};
    int seg_v[2]   = '{4, 8};
    int m_cnt[2];
    int m_sub[2];
    bit m_sat[2];
    bit m_dp[2];

    typedef struct {
        bit st;
        bit ra;
        bit pe;
        bit rn;
        int ecnt;
        bit eout;
        bit edone;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit st, bit ra, bit pe, bit rn, int ecnt, bit eout, bit edone);
        vec_t v;
        v.st = st; v.ra = ra; v.pe = pe; v.rn = rn;
        v.ecnt = ecnt; v.eout = eout; v.edone = edone;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mclear(input int i);
        m_cnt[i] = 0;
        m_sub[i] = 0;
        m_sat[i] = 1'b0;
        m_dp[i]  = 1'b0;
    endtask

    task automatic mstep(input int i);
        if (!rst_n || rearm) begin
            mclear(i);
        end else if (m_sat[i]) begin
            m_dp[i] = 1'b0;
        end else if (start) begin
            mclear(i);
        end else begin
            m_dp[i] = 1'b0;
            m_sub[i]++;
            if (m_sub[i] == presc_v[i]) begin
                m_sub[i] = 0;
                if (m_cnt[i] == 15) begin
                    if (periodic) begin
                        m_cnt[i] = 0;
                        m_dp[i]  = 1'b1;
                    end else begin
                        m_sat[i] = 1'b1;
                    end
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    function automatic int exp_out(input int i);
        if (m_sat[i]) return 0;
        return (m_cnt[i] / seg_v[i]) % 2;
    endfunction

    task automatic check_models();
        chk("model a.count", 32'(count_a), m_cnt[0]);
        chk("model a.out",   32'(out_a),   exp_out(0));
        chk("model a.done",  32'(done_a),  (m_sat[0] || m_dp[0]) ? 1 : 0);
        chk("model a.phase", 32'(phase_a), m_cnt[0] / seg_v[0]);
        chk("model b.count", 32'(count_b), m_cnt[1]);
        chk("model b.out",   32'(out_b),   exp_out(1));
        chk("model b.done",  32'(done_b),  (m_sat[1] || m_dp[1]) ? 1 : 0);
        chk("model b.phase", 32'(phase_b), m_cnt[1] / seg_v[1]);
    endtask

    task automatic cyc(input bit s, input bit r, input bit p, input bit n);
        start    = s;
        rearm    = r;
        periodic = p;
        rst_n    = n;
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        check_models();
    endtask

    initial begin
        bit rs, rr, rp, rn;
        int blk;

        rst_n = 1'b0; start = 1'b1; rearm = 1'b0; periodic = 1'b0;
        mclear(0);
        mclear(1);

        // Directed table for configuration A (WIDTH=4, PHASES=4, PRESC=1).
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        for (int e = 1; e <= 20; e++)
            tbl.push_back(mk(0, 0, 0, 1, (e < 16) ? e : 15,
                             (e < 16) && (((e / 4) % 2) == 1), e >= 16));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(bit'(k % 2), 0, 0, 1, 15, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        for (int e = 2; e <= 5; e++)
            tbl.push_back(mk(0, 0, 0, 1, e, e >= 4, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].st, tbl[k].ra, tbl[k].pe, tbl[k].rn);
            chk($sformatf("tbl[%0d].count", k), 32'(count_a), tbl[k].ecnt);
            chk($sformatf("tbl[%0d].out", k),   32'(out_a),   32'(tbl[k].eout));
            chk($sformatf("tbl[%0d].done", k),  32'(done_a),  32'(tbl[k].edone));
        end

        // Prescaler, configuration B (PRESC=3, PHASES=2).
        cyc(1, 0, 0, 0);
        for (int e = 1; e <= 50; e++) begin
            cyc(0, 0, 0, 1);
            if (e % 3 == 0 && e <= 45) chk("presc count", 32'(count_b), e / 3);
            if (e == 23) chk("presc out before", 32'(out_b), 0);
            if (e == 24) chk("presc out rise", 32'(out_b), 1);
            if (e == 47) chk("presc done early", 32'(done_b), 0);
            if (e == 48) chk("presc done", 32'(done_b), 1);
            if (e == 50) chk("presc hold", 32'(count_b), 15);
        end

        // Periodic wrap, configuration A.
        cyc(1, 0, 0, 0);
        for (int e = 1; e <= 40; e++) begin
            cyc(0, 0, 1, 1);
            chk("periodic count", 32'(count_a), e % 16);
            chk("periodic done",  32'(done_a),  (e == 16 || e == 32) ? 1 : 0);
            chk("periodic out",   32'(out_a),   ((e % 16) / 4) % 2);
        end

        // Mid-run abort at count 9, then restart.
        cyc(1, 0, 0, 0);
        for (int e = 1; e <= 9; e++) cyc(0, 0, 0, 1);
        chk("abort pre count", 32'(count_a), 9);
        chk("abort pre out",   32'(out_a),   0);
        cyc(1, 0, 0, 1);
        chk("abort count", 32'(count_a), 0);
        chk("abort out",   32'(out_a),   0);
        chk("abort done",  32'(done_a),  0);
        for (int e = 1; e <= 4; e++) begin
            cyc(0, 0, 0, 1);
            if (e == 3) chk("restart out low", 32'(out_a), 0);
            if (e == 4) chk("restart out high", 32'(out_a), 1);
        end

        // Reset wins over rearm while saturated.
        cyc(1, 0, 0, 0);
        for (int e = 1; e <= 18; e++) cyc(0, 0, 0, 1);
        chk("sat before reset", 32'(done_a), 1);
        cyc(0, 1, 0, 0);
        chk("rst count", 32'(count_a), 0);
        chk("rst out",   32'(out_a),   0);
        chk("rst done",  32'(done_a),  0);
        chk("rst b count", 32'(count_b), 0);
        for (int e = 1; e <= 3; e++) begin
            cyc(0, 0, 0, 0);
            chk("rst held", 32'(count_a), 0);
        end
        cyc(0, 0, 0, 1);
        chk("rst release a", 32'(count_a), 1);
        chk("rst release b", 32'(count_b), 0);

        // Randomized traffic against the model.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            blk = (k / 200) % 3;
            case (blk)
                0:       rs = ($urandom_range(0, 3) == 0);
                1:       rs = ($urandom_range(0, 127) == 0);
                default: rs = 1'b0;
            endcase
            rr = ($urandom_range(0, 99) == 0);
            rp = ((k / 300) % 2) == 1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 255) != 0);
            cyc(rs, rr, rp, rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wait_count_gen.md
Name: wait_count_gen

Overview:
- Parametrised successor to the single-shot 16-bit wait counter.
- Counts while `start` is low and produces a phase-toggling `out` waveform with PHASES equal segments across the full count range.
- Adds:
  - a prescaler;
  - a selectable one-shot or periodic mode;
  - an explicit rearm;
  - `done`, `phase` and `count` status outputs.
- Used for power-up sequencing delays and slow periodic strobes.

Parameters:
- WIDTH, 16: counter width, legal range 4..32. MAX = 2^WIDTH-1.
- PHASES, 4: number of equal segments. Must be a power of two in the range 2..2^(WIDTH-1). SEG = 2^WIDTH/PHASES.
- PRESC, 1: clock cycles per count step, legal range 1..65535.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  active-low run. 0 = count; 1 = stop/clear, except when saturated.
- rearm  in  1  single-cycle pulse; clears the saturated state
- periodic  in  1  0 = one-shot saturating, 1 = wrap and repeat
- out  out  1  phase waveform
- done  out  1  terminal indication
- phase  out  log2(PHASES)  current segment index = count[WIDTH-1 -: log2(PHASES)]. Combinational from count.
- count  out  WIDTH  current counter value

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a rising edge):
  - count=0, pre_cnt=0, out=0, done=0, state=IDLE.
  - Reset overrides all other inputs, including mid-count and when saturated.
- Priority per edge: rst_n low > rearm > start high > step.
- States: IDLE, RUN, SAT.
  - IDLE: count=0. Moves to RUN on the first edge with start=0 (the counting rule applies at that same edge).
  - RUN → IDLE: when start=1, set count=0, pre_cnt=0, out=0, done=0.
  - RUN → SAT: on the MAX step with periodic=0.
  - SAT:
    - count held at MAX, out=0, done=1.
    - start=1 does NOT clear.
    - start=0 holds.
    - Only rearm or reset leave SAT. rearm sends to IDLE with count=0, pre_cnt=0, out=0, done=0.
  - rearm in IDLE or RUN: same clear to IDLE.
- Prescaler:
  - In RUN, pre_cnt counts 0..PRESC-1.
  - A step occurs on an edge where pre_cnt==PRESC-1; pre_cnt then returns to 0.
  - With PRESC=1, every RUN edge is a step.
- On a step, the current (pre-increment) count is compared against boundaries B_k = k*SEG-1, k=1..PHASES:
  - if count==B_k: out <= (k odd) ? 1 : 0;
  - count <= count+1, unless count==MAX.
  - Net effect: out=0 during segment 0, 1 during segment 1, alternating; out is registered and changes on the edge that leaves a boundary value.
- MAX step:
  - One-shot (periodic=0): out<=0, done<=1, count stays MAX, enter SAT.
  - Periodic (periodic=1): out<=0, count<=0, done pulses 1 for exactly one clock, state stays RUN.
- done is 0 in all other cycles.
- periodic is sampled only at the MAX step; changing it mid-run has no other effect.
- Non-step RUN edges leave count, out and done unchanged (apart from clearing a done pulse).
- start high for a single cycle in RUN fully clears; the next start=0 restarts from 0 with pre_cnt=0.
- rearm and start=0 together on one edge: clear to IDLE. Counting restarts on the following edge.
- All arithmetic is unsigned, WIDTH bits. No overflow wrap except the defined periodic wrap at MAX.

Test Plan:
- One-shot run (WIDTH=4, PHASES=4, PRESC=1). Stimulus: reset, then start=0 held. Required:
  - out=1 while count∈4..7, 0 for 8..11, 1 for 12..15;
  - at the edge leaving count=15, out=0 and done=1;
  - count holds 15 indefinitely.
- Saturation stickiness (same configuration, in SAT). Stimulus: toggle start 1/0 over 20 cycles. Required: count=15, done=1, out=0 throughout. Then rearm pulse → count=0, done=0 next edge.
- Periodic mode (periodic=1, same configuration). Required: count sequence 0..15,0..15; done high exactly one cycle, coinciding with count=0 after wrap; out pattern repeats with period 16.
- Prescaler (PRESC=3, WIDTH=4, PHASES=2). Required: count increments every 3 clocks; out rises on the step leaving count=7 (clock 24 after start falls); done after 48 clocks.
- Mid-run abort. Stimulus: start=1 at count=9, out=0. Required: next edge count=0, out=0, done=0, state IDLE; restart reaches out=1 again after 4 steps.
- Reset priority. Stimulus: rst_n=0 with rearm=1 and start=0 in SAT. Required: all outputs 0 next edge; no counting until rst_n=1.
